// File: rtl/hangman_input_sequencer_if.sv
// Keypad/host-side strobes and game-side handshake for the hangman input sequencer.
interface hangman_input_sequencer_if #(
  parameter int unsigned WORD_LEN = 5
);
  logic [7:0]            key_data;
  logic                  key_valid;
  logic                  key_enter;
  logic                  key_clear;
  logic                  game_rdy;
  logic                  game_over;
  logic [8*WORD_LEN-1:0] setWord;
  logic                  toggle_state;
  logic [7:0]            guess;
  logic [4:0]            guess_cnt;
  logic [2:0]            letters_in;
  logic                  reject;
  logic [1:0]            phase;

  // Keypad/game side: drives strobes and game status, observes the sequencer.
  modport master (
    output key_data, key_valid, key_enter, key_clear, game_rdy, game_over,
    input  setWord, toggle_state, guess, guess_cnt, letters_in, reject, phase
  );

  // Sequencer side.
  modport slave (
    input  key_data, key_valid, key_enter, key_clear, game_rdy, game_over,
    output setWord, toggle_state, guess, guess_cnt, letters_in, reject, phase
  );
endinterface

// File: rtl/hangman_input_sequencer.sv
// Hangman input sequencer: loads the secret word, arms the game, then forwards
// validated, de-duplicated guesses while the game logic is ready.
module hangman_input_sequencer #(
  parameter int unsigned WORD_LEN    = 5,
  parameter bit          ALLOW_LOWER = 1'b1
) (
  input logic                      clk,
  input logic                      nRst,
  hangman_input_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    ARM  = 2'd1,
    PLAY = 2'd2,
    DONE = 2'd3
  } phase_t;

  localparam int unsigned WBITS   = 8 * WORD_LEN;
  localparam logic [2:0]  FULL    = 3'(WORD_LEN);
  localparam logic [4:0]  CNT_MAX = 5'd26;

  phase_t           state_q, state_d;
  logic [WBITS-1:0] word_q, word_d;
  logic [7:0]       guess_q, guess_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [2:0]       li_q, li_d;
  logic [25:0]      used_q, used_d;
  logic             rej_q, rej_d;
  logic             tog_q, tog_d;

  logic             is_upper, is_lower, is_letter;
  logic [7:0]       letter;
  logic [4:0]       idx;

  // Classify the incoming byte, fold lower case, and derive its alphabet index.
  always_comb begin
    is_upper  = (bus.key_data >= 8'h41) && (bus.key_data <= 8'h5A);
    is_lower  = ALLOW_LOWER && (bus.key_data >= 8'h61) && (bus.key_data <= 8'h7A);
    is_letter = is_upper || is_lower;
    letter    = is_lower ? (bus.key_data - 8'h20) : bus.key_data;
    idx       = is_letter ? 5'(letter - 8'h41) : '0;
  end

  // Next-state and next-output logic; strobe priority is clear > game_over > enter > valid.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    guess_d = guess_q;
    cnt_d   = cnt_q;
    li_d    = li_q;
    used_d  = used_q;
    rej_d   = 1'b0;

    unique case (state_q)
      LOAD: begin
        if (bus.key_clear) begin
          word_d = '0;
          li_d   = '0;
        end else if (bus.key_enter) begin
          if (li_q == FULL) state_d = ARM;
          else              rej_d   = 1'b1;
        end else if (bus.key_valid) begin
          if (is_letter && (li_q < FULL)) begin
            // Truncating cast keeps the low WBITS bits: shift left one letter.
            word_d = WBITS'({word_q, letter});
            li_d   = li_q + 3'd1;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      ARM: state_d = PLAY;
      PLAY: begin
        if (bus.key_clear) begin
          state_d = LOAD;
          word_d  = '0;
          guess_d = '0;
          cnt_d   = '0;
          li_d    = '0;
          used_d  = '0;
        end else if (bus.game_over) begin
          state_d = DONE;
        end else if (bus.key_enter) begin
          rej_d = 1'b1;
        end else if (bus.key_valid) begin
          if (is_letter && bus.game_rdy && !used_q[idx]) begin
            guess_d     = letter;
            used_d[idx] = 1'b1;
            cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + 5'd1);
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.key_clear) begin
          state_d = LOAD;
          word_d  = '0;
          guess_d = '0;
          cnt_d   = '0;
          li_d    = '0;
          used_d  = '0;
        end else if (bus.key_enter || bus.key_valid) begin
          rej_d = 1'b1;
        end
      end
    endcase

    // Registered so the pulse lines up with the single cycle spent in ARM.
    tog_d = (state_d == ARM);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= LOAD;
      word_q  <= '0;
      guess_q <= '0;
      cnt_q   <= '0;
      li_q    <= '0;
      used_q  <= '0;
      rej_q   <= 1'b0;
      tog_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      guess_q <= guess_d;
      cnt_q   <= cnt_d;
      li_q    <= li_d;
      used_q  <= used_d;
      rej_q   <= rej_d;
      tog_q   <= tog_d;
    end
  end

  assign bus.setWord      = word_q;
  assign bus.guess        = guess_q;
  assign bus.guess_cnt    = cnt_q;
  assign bus.letters_in   = li_q;
  assign bus.reject       = rej_q;
  assign bus.toggle_state = tog_q;
  assign bus.phase        = state_q;

endmodule

// File: tb/tb_hangman_input_sequencer.sv
// Self-checking bench for hangman_input_sequencer: scenario tasks push expected
// output snapshots to a scoreboard queue and compare them after each strobe.
module tb_hangman_input_sequencer;

  typedef struct packed {
    logic        rej;
    logic        tog;
    logic [1:0]  ph;
    logic [39:0] word;
    logic [7:0]  g;
    logic [4:0]  cnt;
    logic [2:0]  li;
  } obs_t;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic       e;
    logic       c;
    logic       rdy;
    logic       over;
    obs_t       w;
  } step_t;

  localparam logic [39:0] HELLO = 40'h48454C4C4F;
  localparam logic [39:0] WORLD = 40'h574F524C44;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  obs_t sb[$];

  hangman_input_sequencer_if #(.WORD_LEN(5)) bus();

  hangman_input_sequencer #(.WORD_LEN(5), .ALLOW_LOWER(1'b1)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t observed();
    observed = {bus.reject, bus.toggle_state, bus.phase, bus.setWord,
                bus.guess, bus.guess_cnt, bus.letters_in};
  endfunction

  function automatic obs_t mk(logic r, logic t, logic [1:0] p, logic [39:0] w,
                              logic [7:0] g, logic [4:0] c, logic [2:0] l);
    mk = {r, t, p, w, g, c, l};
  endfunction

  function automatic step_t S(logic [7:0] d, logic v, logic e, logic c,
                              logic rdy, logic over, obs_t w);
    S = {d, v, e, c, rdy, over, w};
  endfunction

  // One-cycle strobe; outputs are sampled 1 time unit after the capturing edge.
  task automatic step(input logic [7:0] d, input logic v, input logic e, input logic c);
    @(negedge clk);
    bus.key_data  = d;
    bus.key_valid = v;
    bus.key_enter = e;
    bus.key_clear = c;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key_enter = 1'b0;
    bus.key_clear = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got, want;
    nRst = 1'b0;
    bus.key_data = 8'h41; bus.key_valid = 1'b1; bus.key_enter = 1'b0; bus.key_clear = 1'b0;
    bus.game_rdy = 1'b1; bus.game_over = 1'b0;
    sb.push_back(mk(0, 0, 2'd0, '0, 8'h00, 5'd0, 3'd0));
    repeat (2) @(posedge clk);
    #1;
    want = sb.pop_front(); got = observed(); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL reset got=%h want=%h (rej,tog,ph,word,guess,cnt,li)", got, want);
    end
    @(negedge clk);
    bus.key_valid = 1'b0; bus.game_rdy = 1'b0;
    nRst = 1'b1;
  endtask

  task automatic test_bad_load();
    step_t tbl[$];
    obs_t  got, want;
    tbl.push_back(S(8'h41, 1, 0, 0, 0, 0, mk(0, 0, 0, 40'h41,   0, 0, 1)));
    tbl.push_back(S(8'h42, 1, 0, 0, 0, 0, mk(0, 0, 0, 40'h4142, 0, 0, 2)));
    tbl.push_back(S(8'h00, 0, 1, 0, 0, 0, mk(1, 0, 0, 40'h4142, 0, 0, 2)));
    tbl.push_back(S(8'h00, 0, 0, 0, 0, 0, mk(0, 0, 0, 40'h4142, 0, 0, 2)));
    tbl.push_back(S(8'h31, 1, 0, 0, 0, 0, mk(1, 0, 0, 40'h4142, 0, 0, 2)));
    tbl.push_back(S(8'h40, 1, 0, 0, 0, 0, mk(1, 0, 0, 40'h4142, 0, 0, 2)));
    tbl.push_back(S(8'h5B, 1, 0, 0, 0, 0, mk(1, 0, 0, 40'h4142, 0, 0, 2)));
    tbl.push_back(S(8'h60, 1, 0, 0, 0, 0, mk(1, 0, 0, 40'h4142, 0, 0, 2)));
    tbl.push_back(S(8'h7B, 1, 0, 0, 0, 0, mk(1, 0, 0, 40'h4142, 0, 0, 2)));
    tbl.push_back(S(8'h43, 1, 1, 1, 0, 0, mk(0, 0, 0, 40'h0,    0, 0, 0)));
    foreach (tbl[i]) begin
      bus.game_rdy = tbl[i].rdy; bus.game_over = tbl[i].over;
      sb.push_back(tbl[i].w);
      step(tbl[i].d, tbl[i].v, tbl[i].e, tbl[i].c);
      want = sb.pop_front(); got = observed(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL bad_load[%0d] got=%h want=%h (rej,tog,ph,word,guess,cnt,li)", i, got, want);
      end
    end
  endtask

  task automatic test_load();
    step_t tbl[$];
    obs_t  got, want;
    tbl.push_back(S(8'h48, 1, 0, 0, 0, 0, mk(0, 0, 0, 40'h48,       0, 0, 1)));
    tbl.push_back(S(8'h65, 1, 0, 0, 0, 0, mk(0, 0, 0, 40'h4845,     0, 0, 2)));
    tbl.push_back(S(8'h4C, 1, 0, 0, 0, 0, mk(0, 0, 0, 40'h48454C,   0, 0, 3)));
    tbl.push_back(S(8'h4C, 1, 0, 0, 0, 0, mk(0, 0, 0, 40'h48454C4C, 0, 0, 4)));
    tbl.push_back(S(8'h4F, 1, 0, 0, 0, 0, mk(0, 0, 0, HELLO,        0, 0, 5)));
    tbl.push_back(S(8'h58, 1, 0, 0, 0, 0, mk(1, 0, 0, HELLO,        0, 0, 5)));
    tbl.push_back(S(8'h51, 1, 1, 0, 0, 0, mk(0, 1, 1, HELLO,        0, 0, 5)));
    tbl.push_back(S(8'h51, 1, 0, 0, 1, 0, mk(0, 0, 2, HELLO,        0, 0, 5)));
    tbl.push_back(S(8'h00, 0, 0, 0, 0, 0, mk(0, 0, 2, HELLO,        0, 0, 5)));
    foreach (tbl[i]) begin
      bus.game_rdy = tbl[i].rdy; bus.game_over = tbl[i].over;
      sb.push_back(tbl[i].w);
      step(tbl[i].d, tbl[i].v, tbl[i].e, tbl[i].c);
      want = sb.pop_front(); got = observed(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL load[%0d] got=%h want=%h (rej,tog,ph,word,guess,cnt,li)", i, got, want);
      end
    end
  endtask

  task automatic test_play();
    step_t tbl[$];
    obs_t  got, want;
    tbl.push_back(S(8'h6C, 1, 0, 0, 1, 0, mk(0, 0, 2, HELLO, 8'h4C, 1, 5)));
    tbl.push_back(S(8'h4C, 1, 0, 0, 1, 0, mk(1, 0, 2, HELLO, 8'h4C, 1, 5)));
    tbl.push_back(S(8'h5A, 1, 0, 0, 0, 0, mk(1, 0, 2, HELLO, 8'h4C, 1, 5)));
    tbl.push_back(S(8'h00, 0, 1, 0, 1, 0, mk(1, 0, 2, HELLO, 8'h4C, 1, 5)));
    tbl.push_back(S(8'h5A, 1, 0, 0, 1, 0, mk(0, 0, 2, HELLO, 8'h5A, 2, 5)));
    tbl.push_back(S(8'h61, 1, 0, 0, 1, 0, mk(0, 0, 2, HELLO, 8'h41, 3, 5)));
    tbl.push_back(S(8'h7A, 1, 0, 0, 1, 0, mk(1, 0, 2, HELLO, 8'h41, 3, 5)));
    tbl.push_back(S(8'h5B, 1, 0, 0, 1, 0, mk(1, 0, 2, HELLO, 8'h41, 3, 5)));
    tbl.push_back(S(8'h00, 0, 0, 0, 0, 0, mk(0, 0, 2, HELLO, 8'h41, 3, 5)));
    tbl.push_back(S(8'h41, 1, 0, 0, 1, 0, mk(1, 0, 2, HELLO, 8'h41, 3, 5)));
    foreach (tbl[i]) begin
      bus.game_rdy = tbl[i].rdy; bus.game_over = tbl[i].over;
      sb.push_back(tbl[i].w);
      step(tbl[i].d, tbl[i].v, tbl[i].e, tbl[i].c);
      want = sb.pop_front(); got = observed(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL play[%0d] got=%h want=%h (rej,tog,ph,word,guess,cnt,li)", i, got, want);
      end
    end
  endtask

  task automatic test_end();
    step_t tbl[$];
    obs_t  got, want;
    tbl.push_back(S(8'h51, 1, 0, 0, 1, 1, mk(0, 0, 3, HELLO, 8'h41, 3, 5)));
    tbl.push_back(S(8'h51, 1, 0, 0, 1, 0, mk(1, 0, 3, HELLO, 8'h41, 3, 5)));
    tbl.push_back(S(8'h00, 0, 1, 0, 1, 0, mk(1, 0, 3, HELLO, 8'h41, 3, 5)));
    tbl.push_back(S(8'h00, 0, 0, 0, 1, 0, mk(0, 0, 3, HELLO, 8'h41, 3, 5)));
    tbl.push_back(S(8'h00, 0, 0, 1, 0, 0, mk(0, 0, 0, 40'h0,  8'h00, 0, 0)));
    foreach (tbl[i]) begin
      bus.game_rdy = tbl[i].rdy; bus.game_over = tbl[i].over;
      sb.push_back(tbl[i].w);
      step(tbl[i].d, tbl[i].v, tbl[i].e, tbl[i].c);
      want = sb.pop_front(); got = observed(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL end[%0d] got=%h want=%h (rej,tog,ph,word,guess,cnt,li)", i, got, want);
      end
    end
  endtask

  task automatic test_abort();
    step_t tbl[$];
    obs_t  got, want;
    tbl.push_back(S(8'h57, 1, 0, 0, 0, 0, mk(0, 0, 0, 40'h57,       0, 0, 1)));
    tbl.push_back(S(8'h6F, 1, 0, 0, 0, 0, mk(0, 0, 0, 40'h574F,     0, 0, 2)));
    tbl.push_back(S(8'h52, 1, 0, 0, 0, 0, mk(0, 0, 0, 40'h574F52,   0, 0, 3)));
    tbl.push_back(S(8'h6C, 1, 0, 0, 0, 0, mk(0, 0, 0, 40'h574F524C, 0, 0, 4)));
    tbl.push_back(S(8'h44, 1, 0, 0, 0, 0, mk(0, 0, 0, WORLD,        0, 0, 5)));
    tbl.push_back(S(8'h00, 0, 1, 0, 0, 0, mk(0, 1, 1, WORLD,        0, 0, 5)));
    tbl.push_back(S(8'h00, 0, 0, 0, 0, 0, mk(0, 0, 2, WORLD,        0, 0, 5)));
    tbl.push_back(S(8'h4C, 1, 0, 0, 1, 0, mk(0, 0, 2, WORLD,    8'h4C, 1, 5)));
    for (int pass = 0; pass < 2; pass++) begin
      foreach (tbl[i]) begin
        bus.game_rdy = tbl[i].rdy; bus.game_over = tbl[i].over;
        sb.push_back(tbl[i].w);
        step(tbl[i].d, tbl[i].v, tbl[i].e, tbl[i].c);
        want = sb.pop_front(); got = observed(); checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL abort%0d[%0d] got=%h want=%h (rej,tog,ph,word,guess,cnt,li)", pass, i, got, want);
        end
      end
      if (pass == 0) begin
        @(negedge clk);
        nRst = 1'b0;
        sb.push_back(mk(0, 0, 0, '0, 8'h00, 5'd0, 3'd0));
        @(posedge clk);
        #1;
        want = sb.pop_front(); got = observed(); checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL abort_reset got=%h want=%h (rej,tog,ph,word,guess,cnt,li)", got, want);
        end
        @(negedge clk);
        nRst = 1'b1;
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t       got, want;
    logic [7:0] ch;
    // From PLAY, clear returns to word entry with everything dropped.
    bus.game_rdy = 1'b0; bus.game_over = 1'b0;
    sb.push_back(mk(0, 0, 0, '0, 8'h00, 5'd0, 3'd0));
    step(8'h00, 0, 0, 1);
    want = sb.pop_front(); got = observed(); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL b2b_clear got=%h want=%h (rej,tog,ph,word,guess,cnt,li)", got, want);
    end
    step(8'h48, 1, 0, 0); step(8'h45, 1, 0, 0); step(8'h4C, 1, 0, 0);
    step(8'h4C, 1, 0, 0); step(8'h4F, 1, 0, 0);
    step(8'h00, 0, 1, 0); step(8'h00, 0, 0, 0);
    bus.game_rdy = 1'b1;
    for (int unsigned k = 0; k < 26; k++) begin
      ch = 8'h41 + 8'(k);
      sb.push_back(mk(0, 0, 2, HELLO, ch, 5'(k + 1), 3'd5));
      step(ch, 1, 0, 0);
      want = sb.pop_front(); got = observed(); checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL b2b[%0d] got=%h want=%h (rej,tog,ph,word,guess,cnt,li)", k, got, want);
      end
    end
    sb.push_back(mk(1, 0, 2, HELLO, 8'h5A, 5'd26, 3'd5));
    step(8'h4D, 1, 0, 0);
    want = sb.pop_front(); got = observed(); checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL b2b_sat got=%h want=%h (rej,tog,ph,word,guess,cnt,li)", got, want);
    end
    bus.game_rdy = 1'b0;
  endtask

  initial begin
    bus.key_data = 8'h00; bus.key_valid = 1'b0; bus.key_enter = 1'b0; bus.key_clear = 1'b0;
    bus.game_rdy = 1'b0; bus.game_over = 1'b0;
    test_reset();
    test_bad_load();
    test_load();
    test_play();
    test_end();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
